// File: rtl/hw_trace_accumulator.sv
// Accumulates WINDOW Hamming-weight samples into sum/max/error results,
// then holds the result until the consumer takes it.
module hw_trace_accumulator #(
  parameter int WINDOW = 16,
  parameter int ACC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       hamming_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] trace_sum,
  output logic [3:0]       trace_max,
  output logic             sample_err,
  output logic [15:0]      window_count
);

  localparam int IDX_W = $clog2(WINDOW + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic             live_q;
  logic [ACC_W-1:0] sum_q, sum_d, tsum_q, tsum_d;
  logic [3:0]       max_q, max_d, tmax_q, tmax_d;
  logic             err_q, err_d, terr_q, terr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      wcnt_q, wcnt_d;

  logic [3:0]       samp, new_max;
  logic             over, in_hs, out_hs;
  logic [ACC_W-1:0] new_sum;

  // live_q keeps in_ready low while reset is held, rising on the first edge after.
  assign in_ready     = live_q && (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign in_hs        = in_valid && in_ready;
  assign out_hs       = out_valid && out_ready;
  assign trace_sum    = tsum_q;
  assign trace_max    = tmax_q;
  assign sample_err   = terr_q;
  assign window_count = wcnt_q;

  assign over    = hamming_sum > 4'd8;
  assign samp    = over ? 4'd8 : hamming_sum;
  assign new_sum = sum_q + ACC_W'(samp);
  assign new_max = (samp > max_q) ? samp : max_q;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    max_d   = max_q;
    err_d   = err_q;
    idx_d   = idx_q;
    tsum_d  = tsum_q;
    tmax_d  = tmax_q;
    terr_d  = terr_q;
    wcnt_d  = wcnt_q;
    if (clear) begin
      state_d = ACCUM;
      sum_d   = '0;
      max_d   = '0;
      err_d   = 1'b0;
      idx_d   = '0;
    end else if (in_hs) begin
      sum_d = new_sum;
      max_d = new_max;
      err_d = err_q | over;
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        tsum_d  = new_sum;
        tmax_d  = new_max;
        terr_d  = err_q | over;
        state_d = HOLD;
      end
    end else if (out_hs) begin
      state_d = ACCUM;
      sum_d   = '0;
      max_d   = '0;
      err_d   = 1'b0;
      idx_d   = '0;
      wcnt_d  = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      live_q  <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      tsum_q  <= '0;
      tmax_q  <= '0;
      terr_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      sum_q   <= sum_d;
      max_q   <= max_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      tsum_q  <= tsum_d;
      tmax_q  <= tmax_d;
      terr_q  <= terr_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_hw_trace_accumulator.sv
// Directed bench for hw_trace_accumulator: window vector table plus
// hand sequences for gaps, stall, clear and asynchronous reset.
module tb_hw_trace_accumulator;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, out_ready;
  logic [3:0] hamming_sum;
  logic       in_ready, out_valid, sample_err;
  logic [7:0] trace_sum;
  logic [3:0] trace_max;
  logic [15:0] window_count;

  int errors = 0;
  int checks = 0;
  int exp_wc = 0;

  hw_trace_accumulator #(.WINDOW(16), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .hamming_sum(hamming_sum), .out_valid(out_valid), .out_ready(out_ready),
    .trace_sum(trace_sum), .trace_max(trace_max), .sample_err(sample_err),
    .window_count(window_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] base;
    int         sp_idx;
    logic [3:0] sp_val;
    int         e_sum;
    int         e_max;
    int         e_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds 16 back-to-back samples; result must appear one cycle after the last.
  task automatic send_window(input logic [3:0] base, input int sp_idx, input logic [3:0] sp_val);
    int ready_bad = 0;
    int early_vld = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid    = 1'b1;
      hamming_sum = (i == sp_idx) ? sp_val : base;
      if (!in_ready) ready_bad++;
      if (out_valid) early_vld++;
      tick();
    end
    in_valid = 1'b0;
    chk("ready_in_accum", ready_bad, 0);
    chk("no_early_valid", early_vld, 0);
    chk("valid_latency1", int'(out_valid), 1);
    chk("ready_low_hold", int'(in_ready), 0);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_wc++;
    chk("wc_after_take", int'(window_count), exp_wc);
    chk("valid_after_take", int'(out_valid), 0);
    chk("ready_after_take", int'(in_ready), 1);
  endtask

  initial begin
    tbl[0] = '{4'd3, 0, 4'd3, 48, 3, 0};
    tbl[1] = '{4'd1, 5, 4'd12, 23, 8, 1};
    tbl[2] = '{4'd1, 0, 4'd1, 16, 1, 0};
    tbl[3] = '{4'd0, 15, 4'd15, 8, 8, 1};
    tbl[4] = '{4'd8, 0, 4'd8, 128, 8, 0};
    tbl[5] = '{4'd0, 0, 4'd0, 0, 0, 0};
    tbl[6] = '{4'd2, 3, 4'd9, 38, 8, 1};
    tbl[7] = '{4'd4, 0, 4'd7, 67, 7, 0};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hamming_sum = 4'd0;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(trace_sum), 0);
    chk("rst_max", int'(trace_max), 0);
    chk("rst_err", int'(sample_err), 0);
    chk("rst_wc", int'(window_count), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(in_ready), 1);

    // Table: each window followed immediately (no wait state) by the next.
    for (int v = 0; v < 8; v++) begin
      send_window(tbl[v].base, tbl[v].sp_idx, tbl[v].sp_val);
      chk("tbl_sum", int'(trace_sum), tbl[v].e_sum);
      chk("tbl_max", int'(trace_max), tbl[v].e_max);
      chk("tbl_err", int'(sample_err), tbl[v].e_err);
      take_result();
    end

    // Alternating 0/8 with two idle cycles between samples.
    begin
      int rdy_bad = 0;
      for (int i = 0; i < 16; i++) begin
        in_valid = 1'b1;
        hamming_sum = (i % 2 == 1) ? 4'd8 : 4'd0;
        if (!in_ready) rdy_bad++;
        tick();
        in_valid = 1'b0;
        if (i < 15) begin
          for (int g = 0; g < 2; g++) begin
            if (!in_ready) rdy_bad++;
            tick();
          end
        end
      end
      chk("gap_ready", rdy_bad, 0);
      chk("gap_valid", int'(out_valid), 1);
      chk("gap_sum", int'(trace_sum), 64);
      chk("gap_max", int'(trace_max), 8);
      take_result();
    end

    // Stall in HOLD with in_valid asserted; samples must not be consumed.
    begin
      int bad = 0;
      send_window(4'd5, 0, 4'd5);
      for (int c = 0; c < 5; c++) begin
        in_valid = 1'b1; hamming_sum = 4'd7; out_ready = 1'b0;
        tick();
        if (!out_valid || in_ready || trace_sum != 8'd80 || trace_max != 4'd5 || sample_err) bad++;
      end
      chk("stall_stable", bad, 0);
      in_valid = 1'b1; hamming_sum = 4'd7;
      take_result();
      in_valid = 1'b0;
      send_window(4'd1, 0, 4'd1);
      chk("stall_clean_sum", int'(trace_sum), 16);
      chk("stall_clean_max", int'(trace_max), 1);
      take_result();
    end

    // Clear mid-window, then a full window.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; hamming_sum = 4'd5;
      tick();
    end
    in_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_wc", int'(window_count), exp_wc);
    send_window(4'd2, 0, 4'd2);
    chk("clear_sum", int'(trace_sum), 32);
    chk("clear_max", int'(trace_max), 2);
    take_result();

    // Clear in HOLD drops the pending result but keeps registered outputs.
    send_window(4'd6, 0, 4'd6);
    out_ready = 1'b1; clear = 1'b1;
    tick();
    out_ready = 1'b0; clear = 1'b0;
    chk("hold_clear_valid", int'(out_valid), 0);
    chk("hold_clear_ready", int'(in_ready), 1);
    chk("hold_clear_sum", int'(trace_sum), 96);
    chk("hold_clear_wc", int'(window_count), exp_wc);

    // Asynchronous reset in the middle of HOLD.
    send_window(4'd4, 0, 4'd4);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_ready", int'(in_ready), 0);
    chk("arst_sum", int'(trace_sum), 0);
    chk("arst_max", int'(trace_max), 0);
    chk("arst_wc", int'(window_count), 0);
    #2 rst = 1'b0;
    exp_wc = 0;
    tick();
    chk("arst_ready_after", int'(in_ready), 1);
    send_window(4'd1, 2, 4'd3);
    chk("arst_next_sum", int'(trace_sum), 18);
    take_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hw_trace_accumulator.md
HW_TRACE_ACCUMULATOR -- requirements
Module: hw_trace_accumulator

Interface
REQ-001 SHALL have parameter WINDOW, default 16, giving the number of Hamming-weight samples per trace window (legal range 2..256).
REQ-002 SHALL have parameter ACC_W, default 8, giving the trace_sum width; ACC_W SHALL be >= clog2(8*WINDOW+1).
REQ-003 SHALL have port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port clear  in  1  synchronous abort of the current window.
REQ-006 SHALL have port in_valid  in  1  hamming_sum sample valid.
REQ-007 SHALL have port in_ready  out  1  accumulator able to take a sample.
REQ-008 SHALL have port hamming_sum  in  4  Hamming weight from the data_converter stage; legal range is 0..8.
REQ-009 SHALL have port out_valid  out  1  window result available.
REQ-010 SHALL have port out_ready  in  1  consumer accepts the window result.
REQ-011 SHALL have port trace_sum  out  ACC_W  sum of the window's samples.
REQ-012 SHALL have port trace_max  out  4  largest sample in the window.
REQ-013 SHALL have port sample_err  out  1  at least one sample in the window was above 8.
REQ-014 SHALL have port window_count  out  16  number of window results consumed, modulo 2^16.

Function
REQ-015 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 SHALL accept a sample only on a cycle with in_valid=1 and in_ready=1 (input handshake).
REQ-017 SHALL clamp any accepted sample above 8 to 8 before accumulating and before the max compare, and SHALL set the window's error flag.
REQ-018 SHALL, on each input handshake in ACCUM, add the clamped sample to the running sum, update the running max, and increment the sample index.
REQ-019 SHALL, on the handshake of the WINDOW-th sample, register sum, max and error into trace_sum, trace_max and sample_err, and move to HOLD; out_valid SHALL be 1 on the next cycle (latency 1 clock).
REQ-020 SHALL hold trace_sum, trace_max and sample_err stable throughout HOLD.
REQ-021 SHALL, in HOLD with out_ready=1, complete the output handshake: next cycle out_valid=0, in_ready=1, running sum/max/error/index zeroed, window_count incremented.
REQ-022 SHALL incur no wait state: the first sample of the next window SHALL be acceptable on the cycle immediately after the output handshake.
REQ-023 SHALL ignore in_valid while in HOLD; in_valid without in_ready SHALL NOT change state.
REQ-024 SHALL wrap window_count from 16'hFFFF to 0 without any side effect.
REQ-025 SHALL let clear=1 take priority over every handshake in both states: next cycle state=ACCUM, running values and index zeroed, out_valid=0; window_count and the registered outputs SHALL remain unchanged.
REQ-026 SHALL NOT overflow trace_sum when ACC_W meets REQ-002 (maximum value 8*WINDOW).

Reset
REQ-027 SHALL, while rst=1 and regardless of clk, force: state=ACCUM, out_valid=0, in_ready=0, trace_sum=0, trace_max=0, sample_err=0, window_count=0, running sum/max/error/index=0.
REQ-028 SHALL assert in_ready=1 on the first clock edge after rst deasserts.
REQ-029 SHALL discard any partial window or pending result when rst asserts mid-operation.

Verification
REQ-030 SHALL pass this scenario: WINDOW=16, sixteen back-to-back samples of 3 -> out_valid one cycle after the 16th, trace_sum=48, trace_max=3, sample_err=0; after out_ready, window_count=1.
REQ-031 SHALL pass this scenario: alternating 0/8 samples with in_valid gaps of 2 cycles -> trace_sum=64, trace_max=8, in_ready=1 throughout ACCUM.
REQ-032 SHALL pass this scenario: result pending with out_ready held 0 for 5 cycles while in_valid=1 -> outputs constant, in_ready=0, no sample consumed; on out_ready=1 the next window starts clean.
REQ-033 SHALL pass this scenario: one sample of 12 among fifteen samples of 1 -> trace_sum=23, trace_max=8, sample_err=1; the next window has sample_err=0.
REQ-034 SHALL pass this scenario: clear after 7 samples of 5, then sixteen samples of 2 -> trace_sum=32, window_count incremented only once.
REQ-035 SHALL pass this scenario: rst pulsed mid-HOLD, asynchronous to clk -> out_valid drops immediately, all outputs 0, window_count=0.
